// File: rtl/crop_capture_ctrl_pkg.sv
// Shared constants and types for the crop stage and the frame-capture controller.
package crop_pkg;
  // Crop window: the crop stage decimates the camera image down to this size.
  localparam int CROP_WIN_W = 28;
  localparam int CROP_WIN_H = 28;

  localparam int N_COLS = CROP_WIN_W;
  localparam int N_ROWS = CROP_WIN_H;
  localparam int N_PIX  = N_COLS * N_ROWS;
  localparam int PIX_W  = 8;
  localparam int PTR_W  = 10;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, SEND} cap_state_t;

  // True when a pointer addresses the final sample of a frame.
  function automatic logic is_last(input logic [PTR_W-1:0] ptr);
    return ptr == PTR_W'(N_PIX - 1);
  endfunction
endpackage

// File: rtl/crop_capture_ctrl_if.sv
// Byte stream from the capture controller to the SPART transmitter.
interface crop_capture_ctrl_if;
  import crop_pkg::*;
  logic [PIX_W-1:0] oTX_DATA;
  logic             oTX_VALID;
  logic             oTX_LAST;
  logic             iTX_READY;

  modport master (output oTX_DATA, output oTX_VALID, output oTX_LAST, input iTX_READY);
  modport slave  (input oTX_DATA, input oTX_VALID, input oTX_LAST, output iTX_READY);
endinterface

// File: rtl/crop_capture_ctrl_ram.sv
// Frame buffer: simple dual-port RAM, one write port, registered read port.
module capture_ram
  import crop_pkg::*;
(
  input  logic             iCLK,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [PIX_W-1:0] i_wdata,
  input  logic             i_re,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [PIX_W-1:0] o_rdata
);
  logic [PIX_W-1:0] r_mem [N_PIX];

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge iCLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/crop_capture_ctrl.sv
// Captures one 28x28 frame from the crop stage into a local buffer, then streams it out.
module crop_capture_ctrl
  import crop_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic             iFVAL,
  input  logic             iPIX_DVAL,
  input  logic [PIX_W-1:0] iPIX,
  output logic             oBUF_RST,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR,
  output logic [PTR_W-1:0] oSAMPLE_CNT,
  crop_capture_ctrl_if.master tx
);
  cap_state_t       r_state;
  logic             r_fval_d;
  logic [PTR_W-1:0] r_wr_ptr;    // doubles as the sample count (reaches N_PIX)
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_first;     // first SEND cycle: issue read of byte 0
  logic             r_ld;        // RAM output is valid this cycle: load TX register
  logic             r_buf_rst, r_busy, r_done, r_err;
  logic [PIX_W-1:0] r_tx_data;
  logic             r_tx_valid, r_tx_last;

  logic             w_we, w_acc, w_rd_en;
  logic [PTR_W-1:0] w_rd_addr;
  logic [PIX_W-1:0] w_rdata;

  assign w_we      = (r_state == CAPTURE) && iPIX_DVAL;
  assign w_acc     = r_tx_valid && tx.iTX_READY;
  // Prefetch the next byte in the accept cycle so valid drops for only one cycle.
  assign w_rd_en   = (r_state == SEND) && (r_first || (w_acc && !is_last(r_rd_ptr)));
  assign w_rd_addr = w_acc ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  capture_ram u_ram (
    .iCLK    (iCLK),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (iPIX),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  // Capture/send sequencer with registered status and TX outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state    <= IDLE;
      r_fval_d   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_first    <= 1'b0;
      r_ld       <= 1'b0;
      r_buf_rst  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
    end else begin
      r_fval_d <= iFVAL;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (iSTART) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end
        end
        ARM: begin
          // Only a fresh rising edge starts a capture, so a frame in flight is skipped.
          if (iFVAL && !r_fval_d) begin
            r_state   <= CAPTURE;
            r_wr_ptr  <= '0;
            r_buf_rst <= 1'b0;
          end
        end
        CAPTURE: begin
          if (iPIX_DVAL) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          // A completing write wins over a simultaneous frame-valid drop.
          if (iPIX_DVAL && is_last(r_wr_ptr)) begin
            r_state   <= SEND;
            r_buf_rst <= 1'b1;
            r_rd_ptr  <= '0;
            r_first   <= 1'b1;
          end else if (!iFVAL) begin
            r_err     <= 1'b1;
            r_state   <= ARM;
            r_buf_rst <= 1'b1;
          end
        end
        SEND: begin
          r_first <= 1'b0;
          if (r_first) r_ld <= 1'b1;
          if (r_ld) begin
            r_tx_data  <= w_rdata;
            r_tx_valid <= 1'b1;
            r_tx_last  <= is_last(r_rd_ptr);
            r_ld       <= 1'b0;
          end
          if (w_acc) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            if (is_last(r_rd_ptr)) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
              r_ld     <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oBUF_RST     = r_buf_rst;
  assign oBUSY        = r_busy;
  assign oDONE        = r_done;
  assign oERR         = r_err;
  assign oSAMPLE_CNT  = r_wr_ptr;
  assign tx.oTX_DATA  = r_tx_data;
  assign tx.oTX_VALID = r_tx_valid;
  assign tx.oTX_LAST  = r_tx_last;
endmodule
